// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - game flow state machine: idle, play, respawn and end handling
//
// Sequences a single game: waits for a start-key edge, runs the round timer while
// playing, handles player hits with a timed respawn, and decides win or loss at
// the end of the round. Every output comes straight from a register.
//
// Ports:
//   clk, resetN              clock and asynchronous active-low reset
//   start_key                keypad level, rising edge starts / restarts a game
//   one_sec                  one-cycle tick per second
//   player_hit, tc           one-cycle events: player hit, round timer expired
//   score[15:0]              current score (unsigned)
//   state[1:0]               IDLE=0, PLAY=1, RESPAWN=2, END=3
//   lives[1:0], lives_over   remaining lives, lives exhausted in END
//   timer_en                 round timer enable (PLAY only)
//   game_init, respawn       one-cycle pulses
//   game_over, win, loss     end-of-game status

module game_flow_ctrl #(
  parameter int          LIVES_INIT      = 3,
  parameter logic [15:0] SCORE_THRESHOLD = 16'd10,
  parameter int          RESPAWN_SEC     = 2,
  parameter int          END_SEC         = 3
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        start_key,
  input  logic        one_sec,
  input  logic        player_hit,
  input  logic        tc,
  input  logic [15:0] score,
  output logic [1:0]  state,
  output logic [1:0]  lives,
  output logic        lives_over,
  output logic        timer_en,
  output logic        game_init,
  output logic        respawn,
  output logic        game_over,
  output logic        win,
  output logic        loss
);

  localparam int MAX_SEC = (RESPAWN_SEC > END_SEC) ? RESPAWN_SEC : END_SEC;
  localparam int TW      = ($clog2(MAX_SEC + 1) > 3) ? $clog2(MAX_SEC + 1) : 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PLAY    = 2'd1,
    S_RESPAWN = 2'd2,
    S_END     = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    lives_q, lives_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          key_d_q;
  logic          win_q, win_d;
  logic          loss_q, loss_d;
  logic          lives_over_q, lives_over_d;
  logic          timer_en_q, timer_en_d;
  logic          game_init_q, game_init_d;
  logic          respawn_q, respawn_d;
  logic          game_over_q, game_over_d;

  logic          start_edge;
  logic          score_ok;
  logic [TW-1:0] tick_inc;

  assign start_edge = start_key & ~key_d_q;
  assign score_ok   = (score >= SCORE_THRESHOLD);
  assign tick_inc   = tick_q + TW'(1);

  // State register. key_d resets high so a key held through reset cannot start a game.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= S_IDLE;
      lives_q      <= 2'd0;
      tick_q       <= '0;
      key_d_q      <= 1'b1;
      win_q        <= 1'b0;
      loss_q       <= 1'b0;
      lives_over_q <= 1'b0;
      timer_en_q   <= 1'b0;
      game_init_q  <= 1'b0;
      respawn_q    <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      tick_q       <= tick_d;
      key_d_q      <= start_key;
      win_q        <= win_d;
      loss_q       <= loss_d;
      lives_over_q <= lives_over_d;
      timer_en_q   <= timer_en_d;
      game_init_q  <= game_init_d;
      respawn_q    <= respawn_d;
      game_over_q  <= game_over_d;
    end
  end

  // Next-state logic. The tick counter is cleared on every transition.
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    tick_d  = tick_q;
    win_d   = win_q;
    loss_d  = loss_q;
    case (state_q)
      S_IDLE: begin
        win_d  = 1'b0;
        loss_d = 1'b0;
        if (start_edge) begin
          state_d = S_PLAY;
          lives_d = 2'(LIVES_INIT);
          tick_d  = '0;
        end
      end
      S_PLAY: begin
        win_d  = 1'b0;
        loss_d = 1'b0;
        if (player_hit) begin
          tick_d = '0;
          if (lives_q <= 2'd1) begin
            // Last life gone: loss regardless of a coincident tc.
            lives_d = 2'd0;
            state_d = S_END;
            loss_d  = 1'b1;
          end else begin
            lives_d = lives_q - 2'd1;
            if (tc) begin
              // Timer expiry in the same cycle skips the respawn.
              state_d = S_END;
              win_d   = score_ok;
              loss_d  = ~score_ok;
            end else begin
              state_d = S_RESPAWN;
            end
          end
        end else if (tc) begin
          tick_d  = '0;
          state_d = S_END;
          win_d   = score_ok;
          loss_d  = ~score_ok;
        end
      end
      S_RESPAWN: begin
        if (one_sec) begin
          if (tick_inc == TW'(RESPAWN_SEC)) begin
            state_d = S_PLAY;
            tick_d  = '0;
          end else begin
            tick_d = tick_inc;
          end
        end
      end
      default: begin // S_END
        if (start_edge && (tick_q == TW'(END_SEC))) begin
          state_d = S_IDLE;
          tick_d  = '0;
          win_d   = 1'b0;
          loss_d  = 1'b0;
        end else if (one_sec && (tick_q < TW'(END_SEC))) begin
          tick_d = tick_inc;
        end
      end
    endcase
  end

  // Output logic, computed from the upcoming state so the registered outputs
  // line up with the state they describe.
  always_comb begin
    timer_en_d   = (state_d == S_PLAY);
    game_over_d  = (state_d == S_END);
    lives_over_d = (state_d == S_END) && (lives_d == 2'd0);
    game_init_d  = (state_q == S_IDLE) && (state_d == S_PLAY);
    respawn_d    = (state_q == S_RESPAWN) && (state_d == S_PLAY);
  end

  assign state      = state_q;
  assign lives      = lives_q;
  assign lives_over = lives_over_q;
  assign timer_en   = timer_en_q;
  assign game_init  = game_init_q;
  assign respawn    = respawn_q;
  assign game_over  = game_over_q;
  assign win        = win_q;
  assign loss       = loss_q;

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Parameters SHALL be as follows, one per line as name, default, meaning:
- LIVES_INIT, 3, lives loaded at game start (1..3).
- SCORE_THRESHOLD, 16'd10, minimum score that counts as a win at timeout.
- RESPAWN_SEC, 2, one_sec ticks spent in RESPAWN.
- END_SEC, 3, minimum one_sec ticks in END before restart is accepted.

REQ-002 Ports SHALL be as follows, one per line as name, direction, width, meaning:
- clk  in  1  system clock; the single clock of the block.
- resetN  in  1  asynchronous active-low reset.
- start_key  in  1  level from the keypad; a rising edge is detected internally.
- one_sec  in  1  single-cycle pulse, once per second.
- player_hit  in  1  single-cycle pulse; player touched an explosion or enemy.
- tc  in  1  single-cycle pulse; round timer expired.
- score  in  16  current score, unsigned.
- state  out  2  encoding IDLE=0, PLAY=1, RESPAWN=2, END=3.
- lives  out  2  remaining lives.
- lives_over  out  1  high when lives==0 in END.
- timer_en  out  1  round timer count enable.
- game_init  out  1  one-cycle pulse at game start; clears score, timer and map.
- respawn  out  1  one-cycle pulse; return the player to the spawn tile.
- game_over  out  1  high in END.
- win  out  1  player won; valid in END.
- loss  out  1  player lost; valid in END.

REQ-003 All outputs SHALL be registered.

Function
REQ-004 The start edge SHALL be start_edge = start_key & ~key_d, where key_d is start_key registered once.
REQ-005 IDLE: on start_edge, the block SHALL go to PLAY, load lives=LIVES_INIT, clear win/loss, and pulse game_init for exactly 1 cycle, in the cycle the state becomes PLAY.
REQ-006 PLAY: timer_en SHALL be 1; timer_en SHALL be 0 in every other state.
REQ-007 PLAY, player_hit with lives>1: the block SHALL decrement lives, clear the tick counter and go to RESPAWN.
REQ-008 PLAY, player_hit with lives==1: the block SHALL set lives=0, loss=1, win=0 and go to END.
REQ-009 PLAY, tc without player_hit: the block SHALL go to END with win=1/loss=0 if score>=SCORE_THRESHOLD, else win=0/loss=1; the comparison is unsigned 16-bit.
REQ-010 PLAY, player_hit and tc in the same cycle: the hit SHALL be applied first; if lives reach 0 the result is loss (REQ-008); otherwise the result is END per REQ-009, using the decremented lives, with no RESPAWN.
REQ-011 RESPAWN: the block SHALL count one_sec pulses; on the pulse that makes the count equal RESPAWN_SEC it SHALL go to PLAY and pulse respawn for 1 cycle.
- player_hit and tc are ignored in RESPAWN.
- start_edge is ignored in RESPAWN.
REQ-012 END: game_over=1 and win/loss hold; the block SHALL count one_sec pulses, saturating at END_SEC.
- start_edge with count==END_SEC goes to IDLE and clears win, loss, game_over and lives_over.
- start_edge earlier than that is ignored.
REQ-013 In every state, win and loss SHALL never both be 1.
REQ-014 lives SHALL never underflow below 0.
REQ-015 The tick counter SHALL be at least 3 bits wide and SHALL be cleared on every state entry.
REQ-016 In PLAY and IDLE, game_over, win and loss SHALL be 0.
REQ-017 A player_hit or tc that arrives in IDLE SHALL have no effect.

Reset
REQ-018 On resetN low, at any time including mid-RESPAWN or mid-END, the block SHALL asynchronously set:
- state=IDLE, lives=0, tick counter=0;
- timer_en=0, game_init=0, respawn=0;
- game_over=0, win=0, loss=0, lives_over=0;
- key_d=1, so a key held through reset does not start a game.
REQ-019 After resetN rises, the block SHALL wait for a fresh start_edge before entering PLAY.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- V1: reset, then raise start_key -> 1 cycle later game_init pulses once, state=1, lives=3, timer_en=1.
- V2: in PLAY with score=10, pulse tc -> state=3, win=1, loss=0, game_over=1; with score=9 -> win=0, loss=1.
- V3: lives=3, pulse player_hit -> lives=2, state=2, timer_en=0; after 2 one_sec pulses, respawn pulses once and state=1.
- V4: lives=1, pulse player_hit and tc in the same cycle -> lives=0, lives_over=1, loss=1, win=0, state=3.
- V5: in END, start_edge after 1 one_sec pulse -> remains in END; after 3 pulses, start_edge -> state=0 and all flags 0.
- V6: start_key held high through reset release -> state stays 0 until start_key falls and rises again; reset asserted mid-RESPAWN -> all outputs at reset values immediately.
